// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for an N-digit common-anode 7-segment display.
// Optional leading-zero blanking when SEG_LZB_EN is defined.
module seg_scan_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int DIV         = 1000,
    parameter int SHOW_TICKS  = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [4*N_DIGITS-1:0] data_in_i,
    input  logic [N_DIGITS-1:0]   dp_in_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    output logic [3:0]            nibble_out_o,
    output logic [N_DIGITS-1:0]   digit_sel_n_o,
    output logic                  dp_n_o,
    output logic                  frame_done_o
);

    localparam int CW   = $clog2(DIV);
    localparam int IW   = $clog2(N_DIGITS);
    localparam int TMAX = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
    localparam int SW   = $clog2(TMAX + 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [4*N_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic [N_DIGITS-1:0]   dpd_q, dpd_d, pdp_q, pdp_d;
    logic                  full_q, full_d;
    logic [N_DIGITS-1:0]   sel_q, sel_d;
    logic [3:0]            nib_q, nib_d;
    logic                  dpn_q, dpn_d;
    logic                  fd_q, fd_d;
    logic                  tick, wrap, lzb_dark;

    assign tick = enable_i && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        wrap    = 1'b0;
        if (!enable_i) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            idx_d   = '0;
            slot_d  = '0;
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            case (state_q)
                ST_BLANK: begin
                    if (BLANK_TICKS == 0) begin
                        state_d = ST_SHOW;
                    end else if (tick) begin
                        if (slot_q == SW'(BLANK_TICKS - 1)) begin
                            state_d = ST_SHOW;
                            slot_d  = '0;
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end
                end
                ST_SHOW: begin
                    if (tick) begin
                        if (slot_q == SW'(SHOW_TICKS - 1)) begin
                            state_d = (BLANK_TICKS == 0) ? ST_SHOW : ST_BLANK;
                            slot_d  = '0;
                            if (idx_q == IW'(N_DIGITS - 1)) begin
                                idx_d = '0;
                                wrap  = 1'b1;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end
    end

    // Transfer needs full, capture needs empty, so they never collide.
    always_comb begin
        pend_d = pend_q;
        pdp_d  = pdp_q;
        disp_d = disp_q;
        dpd_d  = dpd_q;
        full_d = full_q;
        if (full_q && (wrap || !enable_i)) begin
            disp_d = pend_q;
            dpd_d  = pdp_q;
            full_d = 1'b0;
        end else if (load_valid_i && !full_q) begin
            pend_d = data_in_i;
            pdp_d  = dp_in_i;
            full_d = 1'b1;
        end
    end

`ifdef SEG_LZB_EN
    logic [N_DIGITS-1:0] lz;

    always_comb begin
        lz       = '1;
        lzb_dark = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            for (int j = 0; j < N_DIGITS; j++) begin
                if (j >= i && (disp_d[4*j +: 4] != 4'h0 || dpd_d[j])) lz[i] = 1'b0;
            end
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i != 0 && idx_d == IW'(i) && lz[i]) lzb_dark = 1'b1;
        end
    end
`else
    assign lzb_dark = 1'b0;
`endif

    always_comb begin
        sel_d = '1;
        nib_d = nib_q;
        dpn_d = 1'b1;
        fd_d  = wrap;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (state_d == ST_SHOW && idx_d == IW'(i)) begin
                nib_d = disp_d[4*i +: 4];
                if (!lzb_dark) begin
                    sel_d[i] = 1'b0;
                    dpn_d    = ~dpd_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            disp_q  <= '0;
            dpd_q   <= '0;
            pend_q  <= '0;
            pdp_q   <= '0;
            full_q  <= 1'b0;
            sel_q   <= '1;
            nib_q   <= '0;
            dpn_q   <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            disp_q  <= disp_d;
            dpd_q   <= dpd_d;
            pend_q  <= pend_d;
            pdp_q   <= pdp_d;
            full_q  <= full_d;
            sel_q   <= sel_d;
            nib_q   <= nib_d;
            dpn_q   <= dpn_d;
            fd_q    <= fd_d;
        end
    end

    assign load_ready_o  = ~full_q;
    assign nibble_out_o  = nib_q;
    assign digit_sel_n_o = sel_q;
    assign dp_n_o        = dpn_q;
    assign frame_done_o  = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIGITS=4, DIV=4, SHOW_TICKS=2, BLANK_TICKS=1.
// Expected scan timing is derived from the cycle count since the scan (re)started.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  nibble_out;
    logic [3:0]  digit_sel_n;
    logic        dp_n;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int k     = -1;

    seg_scan_ctrl #(
        .N_DIGITS(4), .DIV(4), .SHOW_TICKS(2), .BLANK_TICKS(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enable_i(enable),
        .data_in_i(data_in),
        .dp_in_i(dp_in),
        .load_valid_i(load_valid),
        .load_ready_o(load_ready),
        .nibble_out_o(nibble_out),
        .digit_sel_n_o(digit_sel_n),
        .dp_n_o(dp_n),
        .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (k=%0d, t=%0t)", tag, obs, exp, k, $time);
        end
    endtask

    // One clock of scanning; k counts enabled edges since the scan restarted.
    task automatic step(input logic [15:0] dv, input logic [3:0] dpv, input logic rdy);
        int         ph;
        int         d;
        logic       lit;
        logic [3:0] exp_sel;
        logic [15:0] sh;
        @(negedge clk);
        k++;
        ph  = (k + 1) % 12;
        d   = ((k + 1) / 12) % 4;
        lit = (ph >= 4);
        sh  = dv >> (4 * d);
`ifdef SEG_LZB_EN
        if (d > 0 && sh == 16'h0 && (dpv >> d) == 4'h0) lit = 1'b0;
`endif
        exp_sel = 4'hF;
        if (lit) exp_sel[d] = 1'b0;
        chk_val("sel", {28'h0, digit_sel_n}, {28'h0, exp_sel});
        chk_val("dp_n", {31'h0, dp_n}, {31'h0, lit ? ~dpv[d] : 1'b1});
        if (lit) chk_val("nibble", {28'h0, nibble_out}, {28'h0, sh[3:0]});
        chk_val("frame_done", {31'h0, frame_done}, {31'h0, ((k + 1) % 48) == 0});
        chk_val("ready", {31'h0, load_ready}, {31'h0, rdy});
    endtask

    task automatic chk_dark(input string tag);
        chk_val({tag, "_sel"}, {28'h0, digit_sel_n}, 32'hF);
        chk_val({tag, "_dp_n"}, {31'h0, dp_n}, 32'h1);
        chk_val({tag, "_fd"}, {31'h0, frame_done}, 32'h0);
    endtask

    initial begin
        logic [15:0] dv;
        logic [3:0]  dpv;
        logic        rdy;

        // reset
        repeat (3) @(negedge clk);
        chk_dark("rst");
        chk_val("rst_nib", {28'h0, nibble_out}, 32'h0);
        chk_val("rst_ready", {31'h0, load_ready}, 32'h1);
        rst = 1'b0;

        // load 1234 while disabled, then scan two frames
        data_in = 16'h1234; dp_in = 4'b0010; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        chk_val("load_ready_lo", {31'h0, load_ready}, 32'h0);
        @(negedge clk);
        chk_val("load_ready_hi", {31'h0, load_ready}, 32'h1);
        chk_dark("idle");
        enable = 1'b1;
        k = -1;
        for (int i = 0; i < 96; i++) step(16'h1234, 4'b0010, 1'b1);

        // back-to-back loads: ABCD mid-frame, 5678 held until ready
        for (int i = 96; i < 240; i++) begin
            if (i == 100) begin load_valid = 1'b1; data_in = 16'hABCD; dp_in = 4'b1000; end
            if (i == 101) begin data_in = 16'h5678; dp_in = 4'b0000; end
            if (i == 145) load_valid = 1'b0;
            case ((i + 1) / 48)
                2:       begin dv = 16'h1234; dpv = 4'b0010; end
                3:       begin dv = 16'hABCD; dpv = 4'b1000; end
                default: begin dv = 16'h5678; dpv = 4'b0000; end
            endcase
            rdy = (i < 100) || (i == 143) || (i >= 191);
            step(dv, dpv, rdy);
        end

        // enable drop while digit 2 is lit
        for (int i = 240; i < 270; i++) step(16'h5678, 4'b0000, 1'b1);
        chk_val("d2_lit", {28'h0, digit_sel_n}, 32'hB);
        enable = 1'b0;
        @(negedge clk);
        chk_dark("dis");
        @(negedge clk);
        chk_dark("dis2");
        enable = 1'b1;
        k = -1;
        for (int i = 0; i < 20; i++) step(16'h5678, 4'b0000, 1'b1);

        // reset with a pending value: pending must be discarded
        load_valid = 1'b1; data_in = 16'h9999; dp_in = 4'b1111;
        step(16'h5678, 4'b0000, 1'b0);
        load_valid = 1'b0;
        step(16'h5678, 4'b0000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_dark("rst2");
        chk_val("rst2_nib", {28'h0, nibble_out}, 32'h0);
        chk_val("rst2_ready", {31'h0, load_ready}, 32'h1);
        rst = 1'b0;
        k = -1;
        for (int i = 0; i < 96; i++) step(16'h0000, 4'b0000, 1'b1);

        // leading zeros: 0050 with no decimal points
        enable = 1'b0;
        data_in = 16'h0050; dp_in = 4'b0000; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        chk_val("lz_ready_lo", {31'h0, load_ready}, 32'h0);
        @(negedge clk);
        chk_val("lz_ready_hi", {31'h0, load_ready}, 32'h1);
        enable = 1'b1;
        k = -1;
        for (int i = 0; i < 48; i++) step(16'h0050, 4'b0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
